// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the hazard/flush controller of the
// four-stage core (I decode, R register read, F function, D writeback).
//   hz_state_t  : controller state (run, stalling, flushing)
//   NUM_REGS    : architectural register count
//   REG_ADDR_W  : register address width
package h2bp;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_STALL = 2'd1,
    HZ_FLUSH = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// In-flight register write scoreboard.
// Each register keeps a 2-bit count of outstanding writes and a flag saying
// whether the most recently issued writer is a load.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   issue, issue_addr,
//   issue_is_load           : a writer leaves R this cycle
//   wb_en, wb_addr          : D writes the register file this cycle
//   rd_a_addr -> rd_a_pend,
//   rd_a_load               : lookup port A (pending / newest writer is load)
//   rd_b_addr -> rd_b_pend,
//   rd_b_load               : lookup port B
module hz_scoreboard
  import h2bp::*;
#(
  parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue,
  input  logic [REG_ADDR_W-1:0] issue_addr,
  input  logic                  issue_is_load,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [REG_ADDR_W-1:0] rd_a_addr,
  output logic                  rd_a_pend,
  output logic                  rd_a_load,
  input  logic [REG_ADDR_W-1:0] rd_b_addr,
  output logic                  rd_b_pend,
  output logic                  rd_b_load
);

  logic [NUM_REGS-1:0] pend_vec;
  logic [NUM_REGS-1:0] load_vec;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    // r0 is never tracked when it is hardwired to zero.
    localparam bit TRACKED = !(ZERO_REG_HARDWIRED && (r == 0));

    logic [1:0] cnt;
    logic       ld;
    logic       inc;
    logic       dec;

    assign inc = TRACKED && issue && (issue_addr == REG_ADDR_W'(r));
    assign dec = TRACKED && wb_en && (wb_addr == REG_ADDR_W'(r));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= 2'd0;
        ld  <= 1'b0;
      end else if (inc && dec) begin
        // One writer retires while another enters: count is unchanged and
        // the new writer decides whether the register is load-pending.
        ld <= issue_is_load;
      end else if (inc) begin
        cnt <= cnt + 2'd1;
        ld  <= issue_is_load;
      end else if (dec) begin
        cnt <= cnt - 2'd1;
        if (cnt == 2'd1) ld <= 1'b0;
      end
    end

    assign pend_vec[r] = |cnt;
    assign load_vec[r] = ld;
  end

  assign rd_a_pend = pend_vec[rd_a_addr];
  assign rd_a_load = load_vec[rd_a_addr];
  assign rd_b_pend = pend_vec[rd_b_addr];
  assign rd_b_load = load_vec[rd_b_addr];

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and flush controller.
// Stalls the R-stage instruction when an operand cannot be supplied by the
// register-file bypass or D-to-F forwarding, squashes I and R for
// FLUSH_CYCLES cycles when F resolves a taken branch, and counts stall and
// flush events.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   r_valid, r_rs_*, r_rd_*,
//   r_is_load                      : R-stage instruction description
//   branch_taken_f                 : F resolves a taken branch this cycle
//   wb_en, wb_addr                 : D-stage register write
//   stall_pc, stall_r, bubble_f    : stall controls (identical)
//   flush_i, flush_r               : squash controls (identical)
//   busy                           : controller not in HZ_RUN
//   stall_count, flush_count       : wrapping performance counters
// All control outputs are combinational and forced low while rst_n is low.
module hazard_ctrl
  import h2bp::*;
#(
  parameter bit          FWD_EN             = 1'b1,
  parameter int unsigned FLUSH_CYCLES       = 2,
  parameter bit          ZERO_REG_HARDWIRED = 1'b1,
  parameter int unsigned CNT_W              = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  r_valid,
  input  logic                  r_rs_a_en,
  input  logic [REG_ADDR_W-1:0] r_rs_a_addr,
  input  logic                  r_rs_b_en,
  input  logic [REG_ADDR_W-1:0] r_rs_b_addr,
  input  logic                  r_rd_en,
  input  logic [REG_ADDR_W-1:0] r_rd_addr,
  input  logic                  r_is_load,
  input  logic                  branch_taken_f,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  output logic                  stall_pc,
  output logic                  stall_r,
  output logic                  bubble_f,
  output logic                  flush_i,
  output logic                  flush_r,
  output logic                  busy,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic [2:0] FC_RELOAD = 3'(FLUSH_CYCLES - 1);

  hz_state_t  state;
  hz_state_t  state_nx;
  logic [2:0] fcnt;
  logic [2:0] fcnt_nx;

  logic pend_a;
  logic load_a;
  logic pend_b;
  logic load_b;
  logic src_a_haz;
  logic src_b_haz;
  logic hazard;
  logic flush;
  logic stall;
  logic issue;

  // R stage: hazard evaluation against the scoreboard
  hz_scoreboard #(
    .ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED)
  ) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue        (issue),
    .issue_addr   (r_rd_addr),
    .issue_is_load(r_is_load),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .rd_a_addr    (r_rs_a_addr),
    .rd_a_pend    (pend_a),
    .rd_a_load    (load_a),
    .rd_b_addr    (r_rs_b_addr),
    .rd_b_pend    (pend_b),
    .rd_b_load    (load_b)
  );

  // With forwarding, only a load result is too late for D-to-F forwarding.
  assign src_a_haz = r_rs_a_en && (!ZERO_REG_HARDWIRED || (r_rs_a_addr != '0))
                     && pend_a && (load_a || !FWD_EN);
  assign src_b_haz = r_rs_b_en && (!ZERO_REG_HARDWIRED || (r_rs_b_addr != '0))
                     && pend_b && (load_b || !FWD_EN);

  assign hazard = r_valid && (src_a_haz || src_b_haz);
  assign flush  = branch_taken_f || (state == HZ_FLUSH);
  // A squashed instruction must not hold the pipe, so flush wins.
  assign stall  = hazard && !flush;
  assign issue  = r_valid && r_rd_en && !stall && !flush;

  assign stall_pc = rst_n && stall;
  assign stall_r  = rst_n && stall;
  assign bubble_f = rst_n && stall;
  assign flush_i  = rst_n && flush;
  assign flush_r  = rst_n && flush;
  assign busy     = rst_n && (state != HZ_RUN);

  always_comb begin
    state_nx = state;
    fcnt_nx  = fcnt;
    case (state)
      HZ_RUN, HZ_STALL: begin
        if (branch_taken_f) begin
          // The branch cycle itself is the first flush cycle.
          if (FLUSH_CYCLES > 1) begin
            state_nx = HZ_FLUSH;
            fcnt_nx  = FC_RELOAD;
          end else begin
            state_nx = HZ_RUN;
          end
        end else if (hazard) begin
          state_nx = HZ_STALL;
        end else begin
          state_nx = HZ_RUN;
        end
      end
      HZ_FLUSH: begin
        if (branch_taken_f) begin
          fcnt_nx = FC_RELOAD;
        end else if (fcnt <= 3'd1) begin
          fcnt_nx  = 3'd0;
          state_nx = HZ_RUN;
        end else begin
          fcnt_nx = fcnt - 3'd1;
        end
      end
      default: begin
        state_nx = HZ_RUN;
        fcnt_nx  = 3'd0;
      end
    endcase
  end

  // Clock boundary: controller state and performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HZ_RUN;
      fcnt        <= 3'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state       <= state_nx;
      fcnt        <= fcnt_nx;
      stall_count <= stall_count + CNT_W'(stall);
      flush_count <= flush_count + CNT_W'(branch_taken_f);
    end
  end

endmodule
